// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; signs are fixed up in FIN.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiply: {upper partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic                 is_div_q, is_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   mul_step;
    logic [2*WIDTH-1:0]   div_step;
    logic                 neg_res;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Signed ops have op[0] == 0; unsigned ops use raw operands.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    assign mul_step = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opd_q};
    assign div_step  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign neg_res  = sign_a_q ^ sign_b_q;
    assign prod_fix = neg_res ? -acc_q : acc_q;
    // A zero divisor yields remainder = |a|, so the remainder sign fix restores raw a.
    assign quo_fix  = bzero_q ? {WIDTH{1'b1}}
                    : (neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d = op[1];
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    bzero_d  = (b == '0);
                    cnt_d    = '0;
                    acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    opd_d    = op[1] ? b_mag : a_mag;
                    state_d  = StRun;
                end else if (hilo_we) begin
                    if (hilo_sel) begin
                        hi_d = wdata;
                    end else begin
                        lo_d = wdata;
                    end
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_step : mul_step;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFin: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StFin);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hilo_we;
    logic         hilo_sel;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rdata;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hilo_we (hilo_we),
        .hilo_sel(hilo_sel),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] ref_muldiv(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            2'b00: begin
                q = sx * sy;
                return 64'(q);
            end
            2'b01: begin
                uq = ux * uy;
                return uq;
            end
            2'b10: begin
                if (y == '0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == '0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at a negedge with the unit idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit with_we, input bit noisy);
        logic [63:0] res;
        int          cyc;
        bit          got_done;
        res      = ref_muldiv(o, x, y);
        op       = o;
        a        = x;
        b        = y;
        start    = 1'b1;
        hilo_we  = with_we;
        hilo_sel = 1'($urandom);
        wdata    = $urandom;
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                check_eq("busy_run", busy, 1);
                check_eq("hi_hold", hi, exp_hi);
                check_eq("lo_hold", lo, exp_lo);
            end
            if (noisy && !got_done) begin
                start    = 1'($urandom);
                hilo_we  = 1'($urandom);
                hilo_sel = 1'($urandom);
                wdata    = $urandom;
                op       = 2'($urandom);
                a        = $urandom;
                b        = $urandom;
            end else begin
                start   = 1'b0;
                hilo_we = 1'b0;
            end
        end
        check_eq("done_latency", cyc, W + 1);
        @(negedge clk);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        check_eq("done_single", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("hi_result", hi, exp_hi);
        check_eq("lo_result", lo, exp_lo);
        hilo_sel = 1'($urandom);
        #1;
        check_eq("rdata_sel", rdata, hilo_sel ? exp_hi : exp_lo);
    endtask

    task automatic write_hilo(input logic sel, input logic [31:0] data);
        start    = 1'b0;
        hilo_sel = sel;
        hilo_we  = 1'b1;
        wdata    = data;
        #1;
        check_eq("rdata_old", rdata, sel ? exp_hi : exp_lo);
        @(negedge clk);
        hilo_we = 1'b0;
        if (sel) exp_hi = data;
        else     exp_lo = data;
        check_eq("mt_hi", hi, exp_hi);
        check_eq("mt_lo", lo, exp_lo);
        #1;
        check_eq("rdata_new", rdata, data);
    endtask

    initial begin
        int n_done;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        a        = '0;
        b        = '0;
        hilo_we  = 1'b0;
        hilo_sel = 1'b0;
        wdata    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_eq("tp_multu_hi", hi, 32'hFFFF_FFFE);
        check_eq("tp_multu_lo", lo, 32'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd6, 1'b0, 1'b0);
        check_eq("tp_mult_lo", lo, 32'hFFFF_FFD6);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_eq("tp_div_lo", lo, 32'hFFFF_FFFD);
        check_eq("tp_div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        check_eq("tp_divu_lo", lo, 32'd14);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_eq("tp_ovf_lo", lo, 32'h8000_0000);
        run_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
        check_eq("tp_dz_hi", hi, 32'd5);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
        check_eq("tp_sdz_hi", hi, 32'hFFFF_FFFB);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        check_eq("tp_minmin_hi", hi, 32'h4000_0000);

        write_hilo(1'b1, 32'h1234_5678);
        write_hilo(1'b0, 32'hCAFE_F00D);
        run_op(2'b11, 32'd1000, 32'd33, 1'b1, 1'b0);
        run_op(2'b00, 32'hFFFF_FF00, 32'h0000_0123, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) write_hilo(1'($urandom), $urandom);
            run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
        end

        // Abort a MULTU mid-run; hi/lo must clear and no done may follow.
        write_hilo(1'b1, 32'hDEAD_BEEF);
        op    = 2'b01;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_hi", hi, 0);
        check_eq("abort_lo", lo, 0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("abort_no_done", n_done, 0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
